gfx_render_arbiter: RTL and testbench



---
 rtl/gfx_render_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gfx_render_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_render_arbiter.sv
// Round-robin arbiter sharing one pixel renderer between num_req producers.
// The granted producer's pixel is captured and held stable for the whole
// renderer transaction; a one-cycle ack is returned when the renderer is done.
module gfx_render_arbiter #(
    parameter int unsigned point_width = 16,
    parameter int unsigned num_req     = 3,
    parameter int unsigned ptr_width   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [num_req-1:0]             req_write_i,
    input  logic [num_req*point_width-1:0] req_x_i,
    input  logic [num_req*point_width-1:0] req_y_i,
    input  logic [num_req*point_width-1:0] req_z_i,
    input  logic [num_req-1:0]             req_zbuffer_enable_i,
    input  logic [num_req*32-1:0]          req_color_i,
    output logic [num_req-1:0]             req_ack_o,
    output logic [point_width-1:0]         pixel_x_o,
    output logic [point_width-1:0]         pixel_y_o,
    output logic [point_width-1:0]         pixel_z_o,
    output logic                           zbuffer_enable_o,
    output logic [31:0]                    color_o,
    output logic                           write_o,
    input  logic                           ack_i,
    output logic [ptr_width-1:0]           grant_o,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ptr_width-1:0]   ptr_q, ptr_d;
    logic [ptr_width-1:0]   grant_q, grant_d;
    logic [num_req-1:0]     req_ack_q, req_ack_d;
    logic [point_width-1:0] x_q, x_d;
    logic [point_width-1:0] y_q, y_d;
    logic [point_width-1:0] z_q, z_d;
    logic                   ze_q, ze_d;
    logic [31:0]            color_q, color_d;
    logic                   write_q, write_d;
    logic                   busy_q, busy_d;

    // Arbitration signals
    logic [num_req-1:0]     eff_req;
    logic [num_req-1:0]     rot_req;
    logic                   found;
    logic [ptr_width-1:0]   sel;
    int unsigned            idx;
    logic [point_width-1:0] sel_x, sel_y, sel_z;
    logic                   sel_ze;
    logic [31:0]            sel_color;

    // Round-robin pick: rotate the masked request vector so the pointer sits
    // at bit 0, take the first set bit, then map it back to a requester index.
    always_comb begin
        eff_req = req_write_i & ~req_ack_q;
        rot_req = num_req'({eff_req, eff_req} >> ptr_q);
        found   = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int unsigned j = 0; j < num_req; j++) begin
            idx = 32'(ptr_q) + j;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (!found && rot_req[j]) begin
                found = 1'b1;
                sel   = ptr_width'(idx);
            end
        end
    end

    // Select the winning requester's pixel slice
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_z     = '0;
        sel_ze    = 1'b0;
        sel_color = '0;
        for (int unsigned k = 0; k < num_req; k++) begin
            if (sel == ptr_width'(k)) begin
                sel_x     = req_x_i[k*point_width +: point_width];
                sel_y     = req_y_i[k*point_width +: point_width];
                sel_z     = req_z_i[k*point_width +: point_width];
                sel_ze    = req_zbuffer_enable_i[k];
                sel_color = req_color_i[k*32 +: 32];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        req_ack_d = '0;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        ze_d      = ze_q;
        color_d   = color_q;
        write_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    x_d     = sel_x;
                    y_d     = sel_y;
                    z_d     = sel_z;
                    ze_d    = sel_ze;
                    color_d = sel_color;
                    grant_d = sel;
                    write_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ack_i) begin
                    for (int unsigned k = 0; k < num_req; k++) begin
                        req_ack_d[k] = (grant_q == ptr_width'(k));
                    end
                    if (grant_q == ptr_width'(num_req - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_q + ptr_width'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by rst_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            req_ack_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            ze_q      <= 1'b0;
            color_q   <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            req_ack_q <= req_ack_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            ze_q      <= ze_d;
            color_q   <= color_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ack_o        = req_ack_q;
    assign pixel_x_o        = x_q;
    assign pixel_y_o        = y_q;
    assign pixel_z_o        = z_q;
    assign zbuffer_enable_o = ze_q;
    assign color_o          = color_q;
    assign write_o          = write_q;
    assign grant_o          = grant_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_gfx_render_arbiter.sv
// Directed bench for gfx_render_arbiter with 3 requesters.
module tb_gfx_render_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_write;
    logic [47:0] req_x;
    logic [47:0] req_y;
    logic [47:0] req_z;
    logic [2:0]  req_ze;
    logic [95:0] req_color;
    logic [2:0]  req_ack;
    logic [15:0] pixel_x;
    logic [15:0] pixel_y;
    logic [15:0] pixel_z;
    logic        zbuf_en;
    logic [31:0] color;
    logic        write;
    logic        ack;
    logic [1:0]  grant;
    logic        busy;

    int tests    = 0;
    int failures = 0;

    gfx_render_arbiter #(
        .point_width(16),
        .num_req(3),
        .ptr_width(2)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_write_i         (req_write),
        .req_x_i             (req_x),
        .req_y_i             (req_y),
        .req_z_i             (req_z),
        .req_zbuffer_enable_i(req_ze),
        .req_color_i         (req_color),
        .req_ack_o           (req_ack),
        .pixel_x_o           (pixel_x),
        .pixel_y_o           (pixel_y),
        .pixel_z_o           (pixel_z),
        .zbuffer_enable_o    (zbuf_en),
        .color_o             (color),
        .write_o             (write),
        .ack_i               (ack),
        .grant_o             (grant),
        .busy_o              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int k, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic ze, input logic [31:0] c);
        req_x[k*16 +: 16]  = x;
        req_y[k*16 +: 16]  = y;
        req_z[k*16 +: 16]  = z;
        req_ze[k]          = ze;
        req_color[k*32 +: 32] = c;
    endtask

    initial begin
        rst       = 1'b1;
        req_write = '0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        req_ze    = '0;
        req_color = '0;
        ack       = 1'b0;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_write", write, 0);
        check("rst_grant", grant, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_color", color, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Single request from requester 1
        set_pix(1, 16'd5, 16'd7, 16'h1234, 1'b1, 32'hAABBCCDD);
        req_write = 3'b010;
        check("t1_write_before", write, 0);
        step();
        check("t1_write", write, 1);
        check("t1_grant", grant, 1);
        check("t1_busy", busy, 1);
        check("t1_x", pixel_x, 5);
        check("t1_y", pixel_y, 7);
        check("t1_z", pixel_z, 16'h1234);
        check("t1_ze", zbuf_en, 1);
        check("t1_color", color, 32'hAABBCCDD);
        step();
        check("t1_write_drop", write, 0);
        step();
        step();
        check("t1_x_held", pixel_x, 5);
        check("t1_color_held", color, 32'hAABBCCDD);
        check("t1_no_ack_yet", req_ack, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t1_req_ack", req_ack, 3'b010);
        check("t1_idle", busy, 0);
        req_write = 3'b000;
        step();
        check("t1_ack_pulse_end", req_ack, 0);

        // All three requesting continuously, renderer acks 2 cycles after write
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_pix(k, 16'(100 + k), 16'(200 + k), 16'(300 + k), k[0], 32'hC0000000 + 32'(k));
        end
        req_write = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_grant", grant, 64'(i % 3));
            check("rr_write", write, 1);
            check("rr_x", pixel_x, 64'(100 + (i % 3)));
            step();
            check("rr_write_single", write, 0);
            ack = 1'b1;
            step();
            ack = 1'b0;
            check("rr_req_ack", req_ack, 64'(1 << (i % 3)));
            check("rr_write_wait", write, 0);
        end

        // Requester 0 holds its request one cycle after its ack; 2 also requesting
        req_write = 3'b101;
        step();
        check("m_grant0", grant, 0);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("m_ack0", req_ack, 3'b001);
        step();
        check("m_grant2", grant, 2);
        check("m_write2", write, 1);
        req_write = 3'b100;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("m_ack2", req_ack, 3'b100);
        step();
        check("m_stale_write", write, 0);
        check("m_stale_busy", busy, 0);
        req_write = 3'b000;
        step();

        // Requester 1 changes x while its transaction is in flight
        req_x[16 +: 16] = 16'd10;
        req_write = 3'b010;
        step();
        check("x_grant", grant, 1);
        check("x_first", pixel_x, 10);
        step();
        req_x[16 +: 16] = 16'd99;
        step();
        check("x_held_wait", pixel_x, 10);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("x_req_ack", req_ack, 3'b010);
        check("x_held_ack", pixel_x, 10);
        step();
        check("x_masked", write, 0);
        step();
        check("x_regrant_write", write, 1);
        check("x_new", pixel_x, 99);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        req_write = 3'b000;
        step();

        // Spurious ack in IDLE and in ISSUE is ignored
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sp_idle_ack", req_ack, 0);
        check("sp_idle_busy", busy, 0);
        req_write = 3'b111;
        step();
        check("sp_grant", grant, 2);
        check("sp_write", write, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sp_issue_ack", req_ack, 0);
        check("sp_issue_busy", busy, 1);
        step();
        check("sp_wait_busy", busy, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sp_req_ack", req_ack, 3'b100);

        // Reset in WAIT with pointer not at 0
        req_write = 3'b010;
        step();
        check("r_grant1", grant, 1);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("r_ack1", req_ack, 3'b010);
        req_write = 3'b001;
        step();
        check("r_grant0", grant, 0);
        step();
        check("r_wait_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("r_busy", busy, 0);
        check("r_write", write, 0);
        check("r_grant", grant, 0);
        check("r_req_ack", req_ack, 0);
        check("r_pixel_x", pixel_x, 0);
        check("r_pixel_z", pixel_z, 0);
        check("r_ze", zbuf_en, 0);
        check("r_color", color, 0);
        req_write = 3'b101;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("r_after_grant", grant, 0);
        check("r_after_write", write, 1);
        check("r_after_x", pixel_x, 100);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
